// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with a handshaked data-memory access, store lane packing,
// load extraction, a wait-state timeout and the registered write-back slot.
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MEM_Valid,
  input  logic        MEM_DmWr,
  input  logic        MEM_LTypeSel,
  input  logic [1:0]  MEM_WbSel,
  input  logic [31:0] MEM_AluOut,
  input  logic [31:0] MEM_OutB,
  input  logic [4:0]  MEM_Rw,
  input  logic [29:0] MEM_PcAddOne,
  input  logic [1:0]  MEM_SaveType,
  input  logic [2:0]  MEM_LTypeExtOp,
  input  logic        MEM_RfWr,
  output logic        MEM_Stall,
  output logic        DmReq,
  output logic        DmWe,
  output logic [29:0] DmAddr,
  output logic [3:0]  DmBe,
  output logic [31:0] DmWData,
  input  logic [31:0] DmRData,
  input  logic        DmAck,
  output logic        WB_Valid,
  output logic [4:0]  WB_Rw,
  output logic        WB_RfWr,
  output logic [31:0] WB_WData,
  output logic        WB_AdEL,
  output logic        WB_AdES,
  output logic        WB_BusErr
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        memop, st_half, st_byte, st_word, ld_half, ld_byte, half, word, misal, go, tmo;
  logic        req, ack, stall, retire;
  logic [31:0] lane, ld_data, wdata;

  always_comb begin
    memop   = MEM_Valid & (MEM_DmWr | MEM_LTypeSel);
    st_half = MEM_SaveType == 2'b01;
    st_byte = MEM_SaveType == 2'b10;
    st_word = ~st_half & ~st_byte;
    ld_half = (MEM_LTypeExtOp == 3'd3) | (MEM_LTypeExtOp == 3'd4);
    ld_byte = (MEM_LTypeExtOp == 3'd1) | (MEM_LTypeExtOp == 3'd2);
    half    = MEM_DmWr ? st_half : ld_half;
    word    = MEM_DmWr ? st_word : ~ld_half & ~ld_byte;
    misal   = memop & ((half & MEM_AluOut[0]) | (word & |MEM_AluOut[1:0]));
    go      = memop & ~misal;
    tmo     = (state_q == WAIT) && (cnt_q == 8'(TIMEOUT));
    // The timeout cycle drops the request, so an ack arriving then is ignored.
    req     = rst_n & ((state_q == WAIT) ? ~tmo : go);
    ack     = DmAck & req;
    stall   = rst_n & ((state_q == WAIT) ? ~ack & ~tmo : go & ~ack);
    retire  = MEM_Valid & ~stall;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end

  always_comb begin
    state_d = (state_q == IDLE) ? ((go & ~ack) ? WAIT : IDLE) : ((ack | tmo) ? IDLE : WAIT);
    cnt_d   = (state_d == WAIT) ? cnt_q + 8'd1 : 8'd0;
  end

  always_comb begin
    DmReq     = req;
    MEM_Stall = stall;
    DmWe      = req & MEM_DmWr;
    DmAddr    = MEM_AluOut[31:2];
    DmBe      = (~MEM_DmWr | st_word) ? 4'hf : st_half ? (MEM_AluOut[1] ? 4'hc : 4'h3)
              : 4'b0001 << MEM_AluOut[1:0];
    DmWData   = st_byte ? {4{MEM_OutB[7:0]}} : st_half ? {2{MEM_OutB[15:0]}} : MEM_OutB;
    lane      = DmRData >> {MEM_AluOut[1:0], 3'b000};
    ld_data   = (MEM_LTypeExtOp == 3'd1) ? {{24{lane[7]}}, lane[7:0]}
              : (MEM_LTypeExtOp == 3'd2) ? {24'd0, lane[7:0]}
              : (MEM_LTypeExtOp == 3'd3) ? {{16{lane[15]}}, lane[15:0]}
              : (MEM_LTypeExtOp == 3'd4) ? {16'd0, lane[15:0]} : DmRData;
    wdata     = (MEM_WbSel == 2'b01) ? ld_data : (MEM_WbSel == 2'b10) ? {MEM_PcAddOne, 2'b00} : MEM_AluOut;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      WB_Valid  <= 1'b0;
      WB_Rw     <= '0;
      WB_RfWr   <= 1'b0;
      WB_WData  <= '0;
      WB_AdEL   <= 1'b0;
      WB_AdES   <= 1'b0;
      WB_BusErr <= 1'b0;
    end else if (!MEM_Valid) begin
      WB_Valid  <= 1'b0;
      WB_RfWr   <= 1'b0;
      WB_AdEL   <= 1'b0;
      WB_AdES   <= 1'b0;
      WB_BusErr <= 1'b0;
    end else if (retire) begin
      WB_Valid  <= 1'b1;
      WB_Rw     <= MEM_Rw;
      WB_RfWr   <= MEM_RfWr & ~misal & ~tmo;
      WB_WData  <= wdata;
      WB_AdEL   <= misal & ~MEM_DmWr;
      WB_AdES   <= misal & MEM_DmWr;
      WB_BusErr <= tmo;
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed tests of the MEM stage with hand-computed expectations.
module tb_mem_access_stage;
  logic        clk = 0, rst_n = 0;
  logic        MEM_Valid, MEM_DmWr, MEM_LTypeSel, MEM_RfWr, DmAck;
  logic [1:0]  MEM_WbSel, MEM_SaveType;
  logic [31:0] MEM_AluOut, MEM_OutB, DmRData;
  logic [4:0]  MEM_Rw;
  logic [29:0] MEM_PcAddOne;
  logic [2:0]  MEM_LTypeExtOp;
  logic        MEM_Stall, DmReq, DmWe;
  logic [29:0] DmAddr;
  logic [3:0]  DmBe;
  logic [31:0] DmWData, WB_WData;
  logic        WB_Valid, WB_RfWr, WB_AdEL, WB_AdES, WB_BusErr;
  logic [4:0]  WB_Rw;
  int checks = 0, failures = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .MEM_Valid(MEM_Valid), .MEM_DmWr(MEM_DmWr),
    .MEM_LTypeSel(MEM_LTypeSel), .MEM_WbSel(MEM_WbSel), .MEM_AluOut(MEM_AluOut),
    .MEM_OutB(MEM_OutB), .MEM_Rw(MEM_Rw), .MEM_PcAddOne(MEM_PcAddOne),
    .MEM_SaveType(MEM_SaveType), .MEM_LTypeExtOp(MEM_LTypeExtOp), .MEM_RfWr(MEM_RfWr),
    .MEM_Stall(MEM_Stall), .DmReq(DmReq), .DmWe(DmWe), .DmAddr(DmAddr), .DmBe(DmBe),
    .DmWData(DmWData), .DmRData(DmRData), .DmAck(DmAck), .WB_Valid(WB_Valid),
    .WB_Rw(WB_Rw), .WB_RfWr(WB_RfWr), .WB_WData(WB_WData), .WB_AdEL(WB_AdEL),
    .WB_AdES(WB_AdES), .WB_BusErr(WB_BusErr)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    MEM_Valid = 0; MEM_DmWr = 0; MEM_LTypeSel = 0; MEM_RfWr = 0; DmAck = 0;
    MEM_WbSel = 0; MEM_SaveType = 0; MEM_AluOut = 0; MEM_OutB = 0; DmRData = 0;
    MEM_Rw = 0; MEM_PcAddOne = 0; MEM_LTypeExtOp = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle_inputs(); rst_n = 0; MEM_Valid = 1; MEM_LTypeSel = 1; #3;
    checks++; if (DmReq !== 0 || MEM_Stall !== 0) begin failures++; $display("FAIL reset_req req=%b stall=%b want 0 0", DmReq, MEM_Stall); end
    checks++; if ({WB_Valid, WB_RfWr, WB_AdEL, WB_AdES, WB_BusErr, WB_Rw, WB_WData} !== '0) begin failures++; $display("FAIL reset_wb valid=%b data=%h want all 0", WB_Valid, WB_WData); end
    idle_inputs(); step(); rst_n = 1; step();
  endtask

  task automatic test_alu();
    MEM_Valid = 1; MEM_AluOut = 32'h12345678; MEM_WbSel = 2'b00; MEM_RfWr = 1; MEM_Rw = 5; #2;
    checks++; if (MEM_Stall !== 0 || DmReq !== 0) begin failures++; $display("FAIL alu_nostall stall=%b req=%b want 0 0", MEM_Stall, DmReq); end
    step();
    checks++; if (WB_WData !== 32'h12345678 || WB_Rw !== 5 || WB_RfWr !== 1 || WB_Valid !== 1) begin failures++; $display("FAIL alu_wb data=%h rw=%0d rfwr=%b v=%b want 12345678 5 1 1", WB_WData, WB_Rw, WB_RfWr, WB_Valid); end
    idle_inputs(); step();
    checks++; if (WB_Valid !== 0 || WB_RfWr !== 0) begin failures++; $display("FAIL bubble v=%b rfwr=%b want 0 0", WB_Valid, WB_RfWr); end
  endtask

  task automatic test_back_to_back();
    MEM_Valid = 1; MEM_RfWr = 1; MEM_Rw = 3; MEM_AluOut = 32'hDEADBEEF; step();
    checks++; if (WB_WData !== 32'hDEADBEEF || WB_Rw !== 3) begin failures++; $display("FAIL b2b_first data=%h rw=%0d want deadbeef 3", WB_WData, WB_Rw); end
    MEM_Rw = 31; MEM_WbSel = 2'b10; MEM_PcAddOne = 30'h401; #2;
    checks++; if (MEM_Stall !== 0) begin failures++; $display("FAIL b2b_stall stall=%b want 0", MEM_Stall); end
    step();
    checks++; if (WB_WData !== 32'h00001004 || WB_Rw !== 31 || WB_Valid !== 1) begin failures++; $display("FAIL b2b_link data=%h rw=%0d want 00001004 31", WB_WData, WB_Rw); end
    idle_inputs(); step();
  endtask

  task automatic test_store();
    MEM_Valid = 1; MEM_DmWr = 1; MEM_SaveType = 2'b10; MEM_AluOut = 32'h1003; MEM_OutB = 32'h000000AB; DmAck = 1; #2;
    checks++; if (DmReq !== 1 || DmWe !== 1 || DmBe !== 4'b1000 || DmWData !== 32'hABABABAB || DmAddr !== 30'h400) begin failures++; $display("FAIL sb_bus req=%b we=%b be=%b wd=%h addr=%h want 1 1 1000 abababab 400", DmReq, DmWe, DmBe, DmWData, DmAddr); end
    checks++; if (MEM_Stall !== 0) begin failures++; $display("FAIL sb_stall stall=%b want 0", MEM_Stall); end
    step();
    checks++; if (WB_Valid !== 1 || WB_AdES !== 0 || WB_RfWr !== 0) begin failures++; $display("FAIL sb_retire v=%b ades=%b rfwr=%b want 1 0 0", WB_Valid, WB_AdES, WB_RfWr); end
    MEM_SaveType = 2'b01; MEM_AluOut = 32'h2002; MEM_OutB = 32'h1234BEEF; #2;
    checks++; if (DmBe !== 4'b1100 || DmWData !== 32'hBEEFBEEF) begin failures++; $display("FAIL sh_bus be=%b wd=%h want 1100 beefbeef", DmBe, DmWData); end
    step(); idle_inputs(); step();
  endtask

  task automatic test_load(input logic [2:0] op, input logic [31:0] exp);
    int n_stall = 0;
    MEM_Valid = 1; MEM_LTypeSel = 1; MEM_LTypeExtOp = op; MEM_WbSel = 2'b01; MEM_RfWr = 1;
    MEM_Rw = 7; MEM_AluOut = 32'h2002; DmRData = 32'h00F00000;
    for (int i = 0; i < 4; i++) begin
      DmAck = (i == 3); #2;
      if (MEM_Stall) n_stall++;
      checks++; if (DmReq !== 1 || DmWe !== 0 || DmBe !== 4'hf) begin failures++; $display("FAIL ld_req[%0d] req=%b we=%b be=%b want 1 0 1111", i, DmReq, DmWe, DmBe); end
      step();
      if (i == 0) begin checks++; if (WB_Valid !== 0) begin failures++; $display("FAIL ld_noretire v=%b want 0", WB_Valid); end end
    end
    checks++; if (n_stall !== 3) begin failures++; $display("FAIL ld_stall_cycles got=%0d want 3", n_stall); end
    checks++; if (WB_WData !== exp || WB_RfWr !== 1 || WB_Valid !== 1 || WB_Rw !== 7) begin failures++; $display("FAIL ld_wb op=%0d data=%h rfwr=%b v=%b want %h 1 1", op, WB_WData, WB_RfWr, WB_Valid, exp); end
    idle_inputs(); #2;
    checks++; if (DmReq !== 0) begin failures++; $display("FAIL ld_idle req=%b want 0", DmReq); end
    step();
  endtask

  task automatic test_misalign();
    MEM_Valid = 1; MEM_LTypeSel = 1; MEM_LTypeExtOp = 3'd3; MEM_AluOut = 32'h2001; MEM_RfWr = 1; MEM_WbSel = 2'b01; #2;
    checks++; if (DmReq !== 0 || MEM_Stall !== 0) begin failures++; $display("FAIL lh_mis_req req=%b stall=%b want 0 0", DmReq, MEM_Stall); end
    step();
    checks++; if (WB_AdEL !== 1 || WB_AdES !== 0 || WB_RfWr !== 0 || WB_Valid !== 1) begin failures++; $display("FAIL lh_mis_wb adel=%b ades=%b rfwr=%b v=%b want 1 0 0 1", WB_AdEL, WB_AdES, WB_RfWr, WB_Valid); end
    idle_inputs(); MEM_Valid = 1; MEM_DmWr = 1; MEM_SaveType = 2'b00; MEM_AluOut = 32'h2002; #2;
    checks++; if (DmReq !== 0) begin failures++; $display("FAIL sw_mis_req req=%b want 0", DmReq); end
    step();
    checks++; if (WB_AdES !== 1 || WB_AdEL !== 0 || WB_RfWr !== 0) begin failures++; $display("FAIL sw_mis_wb ades=%b adel=%b rfwr=%b want 1 0 0", WB_AdES, WB_AdEL, WB_RfWr); end
    idle_inputs(); step();
  endtask

  task automatic test_timeout();
    int n_req = 0;
    bit done = 0;
    MEM_Valid = 1; MEM_LTypeSel = 1; MEM_LTypeExtOp = 3'd0; MEM_WbSel = 2'b01; MEM_RfWr = 1; MEM_AluOut = 32'h3000;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (DmReq) n_req++;
      if (!MEM_Stall) begin done = 1; break; end
      step();
    end
    checks++; if (!done) begin failures++; $display("FAIL timeout_bound stall never released within 40 cycles"); end
    step();
    checks++; if (n_req !== 16) begin failures++; $display("FAIL timeout_req_cycles got=%0d want 16", n_req); end
    checks++; if (WB_BusErr !== 1 || WB_RfWr !== 0 || WB_Valid !== 1) begin failures++; $display("FAIL timeout_wb buserr=%b rfwr=%b v=%b want 1 0 1", WB_BusErr, WB_RfWr, WB_Valid); end
    idle_inputs(); MEM_Valid = 1; MEM_RfWr = 1; MEM_Rw = 2; MEM_AluOut = 32'h55; #2;
    checks++; if (DmReq !== 0 || MEM_Stall !== 0) begin failures++; $display("FAIL timeout_idle req=%b stall=%b want 0 0", DmReq, MEM_Stall); end
    step();
    checks++; if (WB_BusErr !== 0 || WB_RfWr !== 1 || WB_WData !== 32'h55) begin failures++; $display("FAIL timeout_clear buserr=%b rfwr=%b data=%h want 0 1 00000055", WB_BusErr, WB_RfWr, WB_WData); end
  endtask

  task automatic test_reset_in_wait();
    idle_inputs(); MEM_Valid = 1; MEM_LTypeSel = 1; MEM_AluOut = 32'h3000; MEM_RfWr = 1;
    step(); step();
    checks++; if (DmReq !== 1 || MEM_Stall !== 1) begin failures++; $display("FAIL wait_req req=%b stall=%b want 1 1", DmReq, MEM_Stall); end
    rst_n = 0; #1;
    checks++; if (DmReq !== 0 || MEM_Stall !== 0) begin failures++; $display("FAIL rst_wait_drop req=%b stall=%b want 0 0", DmReq, MEM_Stall); end
    checks++; if ({WB_Valid, WB_RfWr, WB_AdEL, WB_AdES, WB_BusErr, WB_Rw, WB_WData} !== '0) begin failures++; $display("FAIL rst_wait_wb v=%b rfwr=%b data=%h want all 0", WB_Valid, WB_RfWr, WB_WData); end
    idle_inputs(); step(); rst_n = 1; step();
    MEM_Valid = 1; MEM_RfWr = 1; MEM_Rw = 9; MEM_AluOut = 32'hCAFEF00D; #2;
    checks++; if (MEM_Stall !== 0 || DmReq !== 0) begin failures++; $display("FAIL post_rst_idle stall=%b req=%b want 0 0", MEM_Stall, DmReq); end
    step();
    checks++; if (WB_WData !== 32'hCAFEF00D || WB_Rw !== 9 || WB_Valid !== 1) begin failures++; $display("FAIL post_rst_alu data=%h rw=%0d want cafef00d 9", WB_WData, WB_Rw); end
    idle_inputs(); step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_store();
    test_load(3'd1, 32'hFFFFFFF0);
    test_load(3'd2, 32'h000000F0);
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
